// File: rtl/idu_pipe_pkg.sv
// Shared decode definitions for the idu_pipe decode stage: type codes, opcodes,
// immediate-format selectors and fixed system instruction words.
package idu_pipe_pkg;

   typedef enum logic [6:0] {
      TP_NONE = 7'd0, TP_EBREAK, TP_ECALL, TP_MRET,
      U_LUI, U_AUIPC, J_JAL, I_JALR,
      B_BEQ, B_BNE, B_BLT, B_BGE, B_BLTU, B_BGEU,
      I_LB, I_LH, I_LW, I_LBU, I_LHU,
      S_SB, S_SH, S_SW,
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
      R_ADD, R_SUB, R_SLL, R_SLT, R_SLTU, R_XOR, R_SRL, R_SRA, R_OR, R_AND,
      C_CSRRW, C_CSRRS, C_CSRRC, C_CSRRWI, C_CSRRSI, C_CSRRCI
   } tp_e;

   typedef enum logic [3:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J,
      FMT_SYS, FMT_CSR, FMT_CSRI
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I/RV32E instruction decoder (inst -> tp/regs/imm/illegal).
// Define IDU_ZICSR_EN to also decode the CSR instructions, ECALL and MRET.
module idu_dec
   import idu_pipe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NR_REGS = 32,
   parameter int REG_AW  = 5
) (
   input  logic [31:0]       inst,
   output logic [6:0]        tp,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [REG_AW-1:0] rd,
   output logic [XLEN-1:0]   imm,
   output logic              illegal
);

   tp_e                t;
   fmt_e               fmt;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic [4:0]         rs1_v, rs2_v, rd_v;
   logic signed [31:0] imm32;
   logic               bad_reg;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   always_comb begin
      t   = TP_NONE;
      fmt = FMT_NONE;
      case (inst[6:0])
         OP_LUI:   begin t = U_LUI;   fmt = FMT_U; end
         OP_AUIPC: begin t = U_AUIPC; fmt = FMT_U; end
         OP_JAL:   begin t = J_JAL;   fmt = FMT_J; end
         OP_JALR:  begin fmt = FMT_I; if (f3 == 3'b000) t = I_JALR; end
         OP_BRANCH: begin
            fmt = FMT_B;
            case (f3)
               3'b000:  t = B_BEQ;
               3'b001:  t = B_BNE;
               3'b100:  t = B_BLT;
               3'b101:  t = B_BGE;
               3'b110:  t = B_BLTU;
               3'b111:  t = B_BGEU;
               default: t = TP_NONE;
            endcase
         end
         OP_LOAD: begin
            fmt = FMT_I;
            case (f3)
               3'b000:  t = I_LB;
               3'b001:  t = I_LH;
               3'b010:  t = I_LW;
               3'b100:  t = I_LBU;
               3'b101:  t = I_LHU;
               default: t = TP_NONE;
            endcase
         end
         OP_STORE: begin
            fmt = FMT_S;
            case (f3)
               3'b000:  t = S_SB;
               3'b001:  t = S_SH;
               3'b010:  t = S_SW;
               default: t = TP_NONE;
            endcase
         end
         OP_IMM: begin
            fmt = FMT_I;
            case (f3)
               3'b000: t = I_ADDI;
               3'b010: t = I_SLTI;
               3'b011: t = I_SLTIU;
               3'b100: t = I_XORI;
               3'b110: t = I_ORI;
               3'b111: t = I_ANDI;
               3'b001: begin fmt = FMT_SH; if (f7 == F7_ZERO) t = I_SLLI; end
               default: begin
                  fmt = FMT_SH;
                  if (f7 == F7_ZERO)     t = I_SRLI;
                  else if (f7 == F7_ALT) t = I_SRAI;
               end
            endcase
         end
         OP_OP: begin
            fmt = FMT_R;
            if (f7 == F7_ZERO) begin
               case (f3)
                  3'b000:  t = R_ADD;
                  3'b001:  t = R_SLL;
                  3'b010:  t = R_SLT;
                  3'b011:  t = R_SLTU;
                  3'b100:  t = R_XOR;
                  3'b101:  t = R_SRL;
                  3'b110:  t = R_OR;
                  default: t = R_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               if (f3 == 3'b000)      t = R_SUB;
               else if (f3 == 3'b101) t = R_SRA;
            end
         end
         OP_SYSTEM: begin
            fmt = FMT_SYS;
            if (inst == INST_EBREAK) t = TP_EBREAK;
`ifdef IDU_ZICSR_EN
            else if (inst == INST_ECALL) t = TP_ECALL;
            else if (inst == INST_MRET)  t = TP_MRET;
            else begin
               fmt = f3[2] ? FMT_CSRI : FMT_CSR;
               case (f3[1:0])
                  2'b01:   t = f3[2] ? C_CSRRWI : C_CSRRW;
                  2'b10:   t = f3[2] ? C_CSRRSI : C_CSRRS;
                  2'b11:   t = f3[2] ? C_CSRRCI : C_CSRRC;
                  default: t = TP_NONE;
               endcase
            end
`endif
         end
         default: t = TP_NONE;
      endcase
      if (t == TP_NONE) fmt = FMT_NONE;
   end

   // Fields not used by the format stay zero, so the range check can scan all three.
   always_comb begin
      rs1_v = '0;
      rs2_v = '0;
      rd_v  = '0;
      imm32 = '0;
      case (fmt)
         FMT_R:  begin rs1_v = inst[19:15]; rs2_v = inst[24:20]; rd_v = inst[11:7]; end
         FMT_I:  begin rs1_v = inst[19:15]; rd_v = inst[11:7];
                       imm32 = {{20{inst[31]}}, inst[31:20]}; end
         FMT_SH: begin rs1_v = inst[19:15]; rd_v = inst[11:7];
                       imm32 = {27'b0, inst[24:20]}; end
         FMT_S:  begin rs1_v = inst[19:15]; rs2_v = inst[24:20];
                       imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
         FMT_B:  begin rs1_v = inst[19:15]; rs2_v = inst[24:20];
                       imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; end
         FMT_U:  begin rd_v = inst[11:7]; imm32 = {inst[31:12], 12'b0}; end
         FMT_J:  begin rd_v = inst[11:7];
                       imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; end
         FMT_CSR, FMT_CSRI: begin rs1_v = inst[19:15]; rd_v = inst[11:7];
                       imm32 = {20'b0, inst[31:20]}; end
         default: ;
      endcase
   end

   // rs1 of the immediate CSR forms carries zimm, not a register index.
   assign bad_reg = (int'(rd_v) >= NR_REGS) || (int'(rs2_v) >= NR_REGS) ||
                    ((fmt != FMT_CSRI) && (int'(rs1_v) >= NR_REGS));

   assign tp      = t;
   assign rs1     = REG_AW'(rs1_v);
   assign rs2     = REG_AW'(rs2_v);
   assign rd      = REG_AW'(rd_v);
   assign imm     = XLEN'(imm32);
   assign illegal = (t == TP_NONE) || bad_reg;

endmodule

// File: rtl/idu_pipe.sv
// Decode stage between IFU and EXU: idu_dec followed by a 2-entry skid buffer
// with registered in_ready and flush. IDU_ZICSR_EN enables CSR decode in idu_dec.
module idu_pipe
   import idu_pipe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NR_REGS = 32,
   parameter int REG_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [31:0]       in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [6:0]        out_tp,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [REG_AW-1:0] out_rd,
   output logic [XLEN-1:0]   out_imm,
   output logic              out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [6:0]        tp;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   imm;
      logic              illegal;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

   state_e            state, state_nx;
   entry_t            head, tail, dec_e;
   logic [6:0]        d_tp;
   logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
   logic [XLEN-1:0]   d_imm;
   logic              d_illegal;
   logic              push, pop;

   idu_dec #(.XLEN(XLEN), .NR_REGS(NR_REGS), .REG_AW(REG_AW)) u_dec (
      .inst    (in_inst),
      .tp      (d_tp),
      .rs1     (d_rs1),
      .rs2     (d_rs2),
      .rd      (d_rd),
      .imm     (d_imm),
      .illegal (d_illegal)
   );

   assign dec_e = '{pc: in_pc, tp: d_tp, rs1: d_rs1, rs2: d_rs2, rd: d_rd,
                    imm: d_imm, illegal: d_illegal};

   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_nx = state;
      if (flush) state_nx = EMPTY;
      else begin
         case (state)
            EMPTY: if (push) state_nx = ONE;
            ONE: begin
               if (push && !pop)      state_nx = TWO;
               else if (pop && !push) state_nx = EMPTY;
            end
            TWO:     if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         head     <= '0;
         tail     <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx != TWO);
         if (!flush) begin
            case (state)
               EMPTY: if (push) head <= dec_e;
               ONE: begin
                  if (push && pop) head <= dec_e;
                  else if (push)   tail <= dec_e;
               end
               TWO:     if (pop) head <= tail;
               default: ;
            endcase
         end
      end
   end

   assign out_pc      = head.pc;
   assign out_tp      = head.tp;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_rd      = head.rd;
   assign out_imm     = head.imm;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Self-checking bench for idu_pipe: decode vector table, handshake/flush/reset
// sequences, and randomized traffic against a pattern-table reference model.
`timescale 1ns/1ps
module tb_idu_pipe;
   import idu_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [6:0]  out_tp;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        in_ready16, out_valid16, out_illegal16;
   logic [31:0] out_pc16, out_imm16;
   logic [6:0]  out_tp16;
   logic [4:0]  out_rs1_16, out_rs2_16, out_rd16;

   always #5 clk = ~clk;

   idu_pipe dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_tp(out_tp), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_imm(out_imm), .out_illegal(out_illegal));

   idu_pipe #(.NR_REGS(16)) dut16 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid16), .out_ready(out_ready),
      .out_pc(out_pc16), .out_tp(out_tp16), .out_rs1(out_rs1_16), .out_rs2(out_rs2_16),
      .out_rd(out_rd16), .out_imm(out_imm16), .out_illegal(out_illegal16));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  tp;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [6:0]  tp;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        ill, ill16;
   } vec_t;

   typedef enum {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_Z, F_C, F_CI} mfmt_e;
   typedef struct {
      logic [31:0] mask, match;
      tp_e         tp;
      mfmt_e       f;
   } pat_t;

   pat_t pats[$];
   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_entry(input string tag, input exp_t e, input logic [31:0] pc,
                            input logic [6:0] tp, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic ill);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_tp"}, 32'(tp), 32'(e.tp));
      chk({tag, "_rs1"}, 32'(rs1), 32'(e.rs1));
      chk({tag, "_rs2"}, 32'(rs2), 32'(e.rs2));
      chk({tag, "_rd"}, 32'(rd), 32'(e.rd));
      chk({tag, "_imm"}, imm, e.imm);
      chk({tag, "_ill"}, 32'(ill), 32'(e.ill));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addp(input logic [31:0] mask, input logic [31:0] match, input tp_e tp,
                       input mfmt_e f);
      pat_t p;
      p.mask = mask; p.match = match; p.tp = tp; p.f = f;
      pats.push_back(p);
   endtask

   task automatic f3p(input int f3, input logic [6:0] op, input tp_e tp, input mfmt_e f);
      addp(32'h0000_707F, (32'(f3) << 12) | 32'(op), tp, f);
   endtask

   task automatic f7p(input int f7, input int f3, input logic [6:0] op, input tp_e tp,
                      input mfmt_e f);
      addp(32'hFE00_707F, (32'(f7) << 25) | (32'(f3) << 12) | 32'(op), tp, f);
   endtask

   task automatic addv(input logic [31:0] inst, input tp_e tp, input int rs1, input int rs2,
                       input int rd, input logic [31:0] imm, input logic ill, input logic ill16);
      vec_t v;
      v.inst = inst; v.tp = tp; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
      v.imm = imm; v.ill = ill; v.ill16 = ill16;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] sext(input int unsigned v, input int bits);
      if (v >= (32'd1 << (bits - 1))) return v - (32'd1 << bits);
      return v;
   endfunction

   function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst, input int nr);
      exp_t  e;
      mfmt_e f = F_Z;
      bit    found = 0;
      e.pc = pc; e.tp = TP_NONE; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.imm = 0; e.ill = 1;
      foreach (pats[i])
         if (!found && ((inst & pats[i].mask) == pats[i].match)) begin
            found = 1; e.tp = pats[i].tp; f = pats[i].f;
         end
      if (!found) return e;
      case (f)
         F_R:  begin e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; end
         F_I:  begin e.rd = inst[11:7]; e.rs1 = inst[19:15];
                     e.imm = sext(int'(inst[31:20]), 12); end
         F_SH: begin e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.imm = 32'(inst[24:20]); end
         F_S:  begin e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
                     e.imm = sext(int'(inst[31:25]) * 32 + int'(inst[11:7]), 12); end
         F_B:  begin e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
                     e.imm = sext(int'(inst[31]) * 4096 + int'(inst[7]) * 2048 +
                                  int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2, 13); end
         F_U:  begin e.rd = inst[11:7]; e.imm = inst & 32'hFFFF_F000; end
         F_J:  begin e.rd = inst[11:7];
                     e.imm = sext(int'(inst[31]) * (1 << 20) + int'(inst[19:12]) * 4096 +
                                  int'(inst[20]) * 2048 + int'(inst[30:21]) * 2, 21); end
         F_C, F_CI: begin e.rd = inst[11:7]; e.rs1 = inst[19:15];
                     e.imm = 32'(inst[31:20]); end
         default: ;
      endcase
      e.ill = (int'(e.rd) >= nr) || (int'(e.rs2) >= nr) || ((f != F_CI) && (int'(e.rs1) >= nr));
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  ops [0:9];
      logic [31:0] sys [0:2];
      int          k;
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
              OP_IMM, OP_OP, OP_SYSTEM};
      sys = '{INST_EBREAK, INST_ECALL, INST_MRET};
      w = $urandom;
      k = $urandom_range(0, 11);
      if (k < 10) w[6:0] = ops[k];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? F7_ZERO : F7_ALT;
      if (k == 10) w = sys[$urandom_range(0, 2)];
      return w;
   endfunction

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      bit   push, pop;

      addp(32'h7F, 32'(OP_LUI), U_LUI, F_U);
      addp(32'h7F, 32'(OP_AUIPC), U_AUIPC, F_U);
      addp(32'h7F, 32'(OP_JAL), J_JAL, F_J);
      f3p(0, OP_JALR, I_JALR, F_I);
      f3p(0, OP_BRANCH, B_BEQ, F_B);  f3p(1, OP_BRANCH, B_BNE, F_B);
      f3p(4, OP_BRANCH, B_BLT, F_B);  f3p(5, OP_BRANCH, B_BGE, F_B);
      f3p(6, OP_BRANCH, B_BLTU, F_B); f3p(7, OP_BRANCH, B_BGEU, F_B);
      f3p(0, OP_LOAD, I_LB, F_I);  f3p(1, OP_LOAD, I_LH, F_I);  f3p(2, OP_LOAD, I_LW, F_I);
      f3p(4, OP_LOAD, I_LBU, F_I); f3p(5, OP_LOAD, I_LHU, F_I);
      f3p(0, OP_STORE, S_SB, F_S); f3p(1, OP_STORE, S_SH, F_S); f3p(2, OP_STORE, S_SW, F_S);
      f3p(0, OP_IMM, I_ADDI, F_I); f3p(2, OP_IMM, I_SLTI, F_I); f3p(3, OP_IMM, I_SLTIU, F_I);
      f3p(4, OP_IMM, I_XORI, F_I); f3p(6, OP_IMM, I_ORI, F_I);  f3p(7, OP_IMM, I_ANDI, F_I);
      f7p(0, 1, OP_IMM, I_SLLI, F_SH); f7p(0, 5, OP_IMM, I_SRLI, F_SH);
      f7p(32, 5, OP_IMM, I_SRAI, F_SH);
      f7p(0, 0, OP_OP, R_ADD, F_R);  f7p(32, 0, OP_OP, R_SUB, F_R); f7p(0, 1, OP_OP, R_SLL, F_R);
      f7p(0, 2, OP_OP, R_SLT, F_R);  f7p(0, 3, OP_OP, R_SLTU, F_R); f7p(0, 4, OP_OP, R_XOR, F_R);
      f7p(0, 5, OP_OP, R_SRL, F_R);  f7p(32, 5, OP_OP, R_SRA, F_R); f7p(0, 6, OP_OP, R_OR, F_R);
      f7p(0, 7, OP_OP, R_AND, F_R);
      addp(32'hFFFF_FFFF, INST_EBREAK, TP_EBREAK, F_Z);
`ifdef IDU_ZICSR_EN
      addp(32'hFFFF_FFFF, INST_ECALL, TP_ECALL, F_Z);
      addp(32'hFFFF_FFFF, INST_MRET, TP_MRET, F_Z);
      f3p(1, OP_SYSTEM, C_CSRRW, F_C);  f3p(2, OP_SYSTEM, C_CSRRS, F_C);
      f3p(3, OP_SYSTEM, C_CSRRC, F_C);  f3p(5, OP_SYSTEM, C_CSRRWI, F_CI);
      f3p(6, OP_SYSTEM, C_CSRRSI, F_CI); f3p(7, OP_SYSTEM, C_CSRRCI, F_CI);
`endif

      addv(32'h0050_0093, I_ADDI, 0, 0, 1, 32'd5, 0, 0);
      addv(32'h0020_A423, S_SW, 1, 2, 0, 32'd8, 0, 0);
      addv(32'hFE00_0EE3, B_BEQ, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
      addv(32'h0010_0893, I_ADDI, 0, 0, 17, 32'd1, 0, 1);
      addv(32'hFFFF_FFFF, TP_NONE, 0, 0, 0, 32'd0, 1, 1);
      addv(32'h1234_52B7, U_LUI, 0, 0, 5, 32'h1234_5000, 0, 0);
      addv(32'h0080_006F, J_JAL, 0, 0, 0, 32'd8, 0, 0);
      addv(32'h4072_5193, I_SRAI, 4, 0, 3, 32'd7, 0, 0);
      addv(32'h0200_9093, TP_NONE, 0, 0, 0, 32'd0, 1, 1);
      addv(32'h4073_02B3, R_SUB, 6, 7, 5, 32'd0, 0, 0);
      addv(32'h0010_0073, TP_EBREAK, 0, 0, 0, 32'd0, 0, 0);
      addv(32'hFFC1_2503, I_LW, 2, 0, 10, 32'hFFFF_FFFC, 0, 0);
      addv(32'h01FF_8FB3, R_ADD, 31, 31, 31, 32'd0, 0, 1);
`ifdef IDU_ZICSR_EN
      addv(32'h3001_10F3, C_CSRRW, 2, 0, 1, 32'h300, 0, 0);
      addv(32'h0000_0073, TP_ECALL, 0, 0, 0, 32'd0, 0, 0);
      addv(32'h340A_50F3, C_CSRRWI, 20, 0, 1, 32'h340, 0, 0);
`else
      addv(32'h3001_10F3, TP_NONE, 0, 0, 0, 32'd0, 1, 1);
      addv(32'h0000_0073, TP_NONE, 0, 0, 0, 32'd0, 1, 1);
      addv(32'h340A_50F3, TP_NONE, 0, 0, 0, 32'd0, 1, 1);
`endif

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_pc", out_pc, 0);
      chk("rst_tp", 32'(out_tp), 32'(TP_NONE));
      chk("rst_regs", {17'b0, out_rs1, out_rs2, out_rd}, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_ill", 32'(out_illegal), 0);

      // decode table, one instruction at a time with out_ready high
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h1000 + 32'(i) * 4;
         tick();
         in_valid = 1'b0;
         e.pc = in_pc; e.tp = vecs[i].tp; e.rs1 = vecs[i].rs1; e.rs2 = vecs[i].rs2;
         e.rd = vecs[i].rd; e.imm = vecs[i].imm; e.ill = vecs[i].ill;
         chk("tab_valid", 32'(out_valid), 1);
         chk_entry("tab", e, out_pc, out_tp, out_rs1, out_rs2, out_rd, out_imm, out_illegal);
         e.ill = vecs[i].ill16;
         chk_entry("tab16", e, out_pc16, out_tp16, out_rs1_16, out_rs2_16, out_rd16,
                   out_imm16, out_illegal16);
         tick();
      end
      chk("tab_drain", 32'(out_valid), 0);

      // backpressure: two accepted, third held until the first pop
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0050_0093;
      tick();
      chk("bp_ready1", 32'(in_ready), 1);
      chk("bp_pc1", out_pc, 32'h100);
      in_pc = 32'h104; in_inst = 32'hFFC1_2503;
      tick();
      chk("bp_ready2", 32'(in_ready), 0);
      in_pc = 32'h108; in_inst = 32'h4073_02B3;
      tick();
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_pc", out_pc, 32'h100);
      chk("bp_hold_tp", 32'(out_tp), 32'(I_ADDI));
      out_ready = 1'b1;
      tick();
      chk("bp_pop1_pc", out_pc, 32'h104);
      chk("bp_pop1_tp", 32'(out_tp), 32'(I_LW));
      chk("bp_pop1_ready", 32'(in_ready), 1);
      tick();
      chk("bp_pop2_pc", out_pc, 32'h108);
      chk("bp_pop2_tp", 32'(out_tp), 32'(R_SUB));
      chk("bp_pop2_valid", 32'(out_valid), 1);
      in_valid = 1'b0;
      tick();
      chk("bp_empty", 32'(out_valid), 0);

      // flush with both entries occupied
      out_ready = 1'b0; in_valid = 1'b1;
      in_pc = 32'h200; tick();
      in_pc = 32'h204; tick();
      chk("fl2_full", 32'(in_ready), 0);
      flush = 1'b1; in_pc = 32'h208;
      tick();
      chk("fl2_valid", 32'(out_valid), 0);
      chk("fl2_ready", 32'(in_ready), 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("fl2_stay", 32'(out_valid), 0);

      // flush while an input would otherwise be accepted
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
      tick();
      flush = 1'b1; in_pc = 32'h304;
      tick();
      chk("fl1_valid", 32'(out_valid), 0);
      chk("fl1_ready", 32'(in_ready), 1);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk("fl1_stay", 32'(out_valid), 0);
      in_valid = 1'b1; in_pc = 32'h308; in_inst = 32'h0050_0093;
      tick();
      in_valid = 1'b0;
      chk("fl1_next_pc", out_pc, 32'h308);
      chk("fl1_next_valid", 32'(out_valid), 1);

      // asynchronous reset while holding an entry
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ready", 32'(in_ready), 1);
      chk("arst_pc", out_pc, 0);
      chk("arst_tp", 32'(out_tp), 32'(TP_NONE));
      chk("arst_imm", out_imm, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_after", 32'(out_valid), 0);

      // randomized traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         chk("rnd_valid", 32'(out_valid), 32'(sb.size() > 0));
         chk("rnd_ready", 32'(in_ready), 32'(sb.size() < 2));
         if (sb.size() > 0)
            chk_entry("rnd", sb[0], out_pc, out_tp, out_rs1, out_rs2, out_rd, out_imm,
                      out_illegal);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         push = in_valid && (sb.size() < 2) && !flush;
         pop  = out_ready && (sb.size() > 0);
         e = model(in_pc, in_inst, 32);
         tick();
         if (flush) sb.delete();
         else begin
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back(e);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
